// File: rtl/i2c_pkg.sv
// Shared state encoding and statistics constants for the I2C register-map controller.
package i2c_pkg;

    typedef logic [2:0] state_t;

    localparam state_t PTR        = 3'd0;
    localparam state_t WDATA      = 3'd1;
    localparam state_t RD_ISSUE   = 3'd2;
    localparam state_t RD_CAPTURE = 3'd3;
    localparam state_t RD_HOLD    = 3'd4;

    localparam int STATS_WIDTH = 16;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
        return (v == {STATS_WIDTH{1'b1}}) ? v : v + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/i2c_reg_ptr.sv
// Register pointer: load from a received byte (reduced modulo REG_COUNT) or
// increment with wrap at REG_COUNT-1.
module i2c_reg_ptr #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_COUNT  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [7:0]            load_val,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam logic [31:0]           REG_COUNT_W = 32'(REG_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR    = ADDR_WIDTH'(REG_COUNT - 1);

    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH-1:0] ptr_next_s;
    logic [31:0]           load_mod_s;

    // Next pointer value: load has precedence over increment.
    always_comb begin
        load_mod_s = {24'd0, load_val} % REG_COUNT_W;
        ptr_next_s = ptr_r;
        if (load) begin
            ptr_next_s = load_mod_s[ADDR_WIDTH-1:0];
        end else if (inc) begin
            ptr_next_s = (ptr_r == LAST_PTR) ? {ADDR_WIDTH{1'b0}} : ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// I2C register-map controller between the slave's AXI-stream ports and a register file.
// Optional saturating write/read counters are enabled with I2C_REG_CTRL_STATS_EN.
module i2c_slave_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_COUNT  = 2**ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_axis_data_tdata,
    input  logic                   s_axis_data_tvalid,
    output logic                   s_axis_data_tready,
    input  logic                   s_axis_data_tlast,
    output logic [7:0]             m_axis_data_tdata,
    output logic                   m_axis_data_tvalid,
    input  logic                   m_axis_data_tready,
    output logic                   m_axis_data_tlast,
    output logic [ADDR_WIDTH-1:0]  reg_addr,
    output logic                   reg_wr_en,
    output logic [7:0]             reg_wr_data,
    output logic                   reg_rd_en,
    input  logic [7:0]             reg_rd_data,
`ifdef I2C_REG_CTRL_STATS_EN
    output logic [STATS_WIDTH-1:0] wr_count,
    output logic [STATS_WIDTH-1:0] rd_count,
`endif
    output logic [ADDR_WIDTH-1:0]  reg_ptr
);

    state_t                state_r, state_next_s;
    logic                  first_byte_r, first_byte_s;
    logic                  tready_r, tready_s;
    logic                  tvalid_r, tvalid_s;
    logic [7:0]            tdata_r, tdata_s;
    logic                  wr_en_r, wr_en_s;
    logic [7:0]            wr_data_r, wr_data_s;
    logic                  rd_en_r, rd_en_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] ptr_s;
    logic                  in_write_s, wr_accept_s, rd_req_s, hs_s;
    logic                  ptr_load_s, ptr_inc_s;

    // Event decode; a pending write beat always wins over a read request.
    always_comb begin
        in_write_s  = (state_r == PTR) || (state_r == WDATA);
        wr_accept_s = in_write_s && s_axis_data_tvalid && tready_r;
        rd_req_s    = in_write_s && m_axis_data_tready && !tvalid_r && !wr_accept_s;
        hs_s        = (state_r == RD_HOLD) && tvalid_r && m_axis_data_tready;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PTR, WDATA: begin
                if (wr_accept_s) begin
                    state_next_s = s_axis_data_tlast ? PTR : WDATA;
                end else if (rd_req_s) begin
                    state_next_s = RD_ISSUE;
                end else begin
                    state_next_s = state_r;
                end
            end
            RD_ISSUE:   state_next_s = RD_CAPTURE;
            RD_CAPTURE: state_next_s = RD_HOLD;
            RD_HOLD: begin
                if (hs_s) begin
                    state_next_s = first_byte_r ? PTR : WDATA;
                end else begin
                    state_next_s = RD_HOLD;
                end
            end
            default:    state_next_s = PTR;
        endcase
    end

    // Output decode; tready drops for one cycle after a write that collided with a read request.
    always_comb begin
        tready_s     = ((state_next_s == PTR) || (state_next_s == WDATA)) && !(wr_accept_s && m_axis_data_tready);
        tvalid_s     = (state_next_s == RD_HOLD);
        rd_en_s      = (state_next_s == RD_ISSUE);
        wr_en_s      = wr_accept_s && (state_r == WDATA);
        ptr_load_s   = wr_accept_s && (state_r == PTR);
        ptr_inc_s    = wr_en_s || hs_s;
        wr_data_s    = wr_en_s ? s_axis_data_tdata : wr_data_r;
        tdata_s      = (state_r == RD_CAPTURE) ? reg_rd_data : tdata_r;
        first_byte_s = wr_accept_s ? s_axis_data_tlast : first_byte_r;
    end

    // State register and registered outputs; reg_addr carries the pre-increment pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= PTR;
            first_byte_r <= 1'b1;
            tready_r     <= 1'b0;
            tvalid_r     <= 1'b0;
            tdata_r      <= 8'h00;
            wr_en_r      <= 1'b0;
            wr_data_r    <= 8'h00;
            rd_en_r      <= 1'b0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r      <= state_next_s;
            first_byte_r <= first_byte_s;
            tready_r     <= tready_s;
            tvalid_r     <= tvalid_s;
            tdata_r      <= tdata_s;
            wr_en_r      <= wr_en_s;
            wr_data_r    <= wr_data_s;
            rd_en_r      <= rd_en_s;
            addr_r       <= ptr_s;
        end
    end

    i2c_reg_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (ptr_load_s),
        .load_val (s_axis_data_tdata),
        .inc      (ptr_inc_s),
        .ptr      (ptr_s)
    );

`ifdef I2C_REG_CTRL_STATS_EN
    logic [STATS_WIDTH-1:0] wr_count_r, rd_count_r;

    // Saturating write-strobe and read-handshake counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_r <= {STATS_WIDTH{1'b0}};
            rd_count_r <= {STATS_WIDTH{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_count_r <= sat_inc(wr_count_r);
            end
            if (hs_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end
        end
    end

    assign wr_count = wr_count_r;
    assign rd_count = rd_count_r;
`endif

    assign s_axis_data_tready = tready_r;
    assign m_axis_data_tdata  = tdata_r;
    assign m_axis_data_tvalid = tvalid_r;
    assign m_axis_data_tlast  = 1'b0;
    assign reg_addr           = addr_r;
    assign reg_wr_en          = wr_en_r;
    assign reg_wr_data        = wr_data_r;
    assign reg_rd_en          = rd_en_r;
    assign reg_ptr            = ptr_s;

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Scoreboard bench for i2c_slave_reg_ctrl with a non-power-of-2 register count (5).
// Counter checks run when I2C_REG_CTRL_STATS_EN is defined.
module tb_i2c_slave_reg_ctrl;

    localparam int AW = 3;
    localparam int RC = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [AW-1:0] reg_addr, reg_ptr;
    logic          reg_wr_en, reg_rd_en;
    logic [7:0]    reg_wr_data, reg_rd_data;
`ifdef I2C_REG_CTRL_STATS_EN
    logic [15:0]   wr_count, rd_count;
`endif

    always #5 clk = ~clk;

    i2c_slave_reg_ctrl #(.ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .s_axis_data_tlast  (s_tlast),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready),
        .m_axis_data_tlast  (m_tlast),
        .reg_addr           (reg_addr),
        .reg_wr_en          (reg_wr_en),
        .reg_wr_data        (reg_wr_data),
        .reg_rd_en          (reg_rd_en),
        .reg_rd_data        (reg_rd_data),
`ifdef I2C_REG_CTRL_STATS_EN
        .wr_count           (wr_count),
        .rd_count           (rd_count),
`endif
        .reg_ptr            (reg_ptr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    int last_rd_cyc = -10;
    int b2b_cnt = 0;

    logic [7:0]  regfile [RC];
    logic [7:0]  mem_m [RC];
    int          ptr_m;
    bit          first_m;
    logic [15:0] wr_q [$];
    logic [7:0]  rda_q [$];
    logic [7:0]  rdd_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous register file: read data valid one cycle after reg_rd_en.
    always @(posedge clk) begin
        if (reg_wr_en) regfile[reg_addr] <= reg_wr_data;
        if (reg_rd_en) reg_rd_data <= regfile[reg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: pointer byte, then register writes with auto-increment.
    task automatic model_byte(input logic [7:0] b, input bit last);
        if (first_m) begin
            ptr_m = int'(b) % RC;
        end else begin
            wr_q.push_back({8'(ptr_m), b});
            mem_m[ptr_m] = b;
            ptr_m = (ptr_m + 1) % RC;
        end
        first_m = last;
    endtask

    task automatic model_read();
        rda_q.push_back(8'(ptr_m));
        rdd_q.push_back(mem_m[ptr_m]);
        ptr_m = (ptr_m + 1) % RC;
    endtask

    // Monitor: compares every strobe and read handshake with the scoreboard queues.
    initial begin
        logic [15:0] e;
        logic [7:0]  d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (reg_wr_en) begin
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_addr", 32'(reg_addr), 32'(e[15:8]));
                        check("wr_data", 32'(reg_wr_data), 32'(e[7:0]));
                    end
                    if (last_wr_cyc == cyc - 1) b2b_cnt++;
                    last_wr_cyc = cyc;
                end
                if (reg_rd_en) begin
                    if (rda_q.size() == 0) begin
                        check("rd_unexpected", 32'd1, 32'd0);
                    end else begin
                        d = rda_q.pop_front();
                        check("rd_addr", 32'(reg_addr), 32'(d));
                    end
                    last_rd_cyc = cyc;
                end
                if (m_tvalid && m_tready) begin
                    if (rdd_q.size() == 0) begin
                        check("rd_data_unexpected", 32'd1, 32'd0);
                    end else begin
                        d = rdd_q.pop_front();
                        check("rd_data", 32'(m_tdata), 32'(d));
                    end
                end
            end
        end
    end

    task automatic idle_w();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int n = 0;
        model_byte(b, last);
        s_tdata  = b;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) check("s_tready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic read_one();
        int k = 0;
        idle_w();
        model_read();
        m_tready = 1'b1;
        @(negedge clk);
        while (!m_tvalid && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!m_tvalid) check("rd_timeout", 32'd0, 32'd1);
        else check("rd_latency", 32'(k - 1), 32'd2);
        @(posedge clk); #1;
        m_tready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_tdata = 8'h00; m_tready = 1'b0;
        idle_w();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ptr_m = 0;
        first_m = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, nb, nr, tr_hi, n;
        bit endl;
        logic [7:0] b;
        for (int i = 0; i < RC; i++) begin
            regfile[i] = 8'($urandom);
            mem_m[i]   = regfile[i];
        end
        do_reset();
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_ptr", 32'(reg_ptr), 32'd0);
        @(posedge clk); #1;
        check("ptr_state_tready", 32'(s_tready), 32'd1);

        // Pointer then two back-to-back data bytes.
        b0 = b2b_cnt;
        send(8'h10, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        idle_w();
        @(posedge clk); #1;
        check("t1_b2b", 32'(b2b_cnt - b0), 32'd1);
        check("t1_ptr", 32'(reg_ptr), 32'(ptr_m));

        // Pointer write followed by three reads.
        send(8'h20, 1'b1);
        for (int i = 0; i < 3; i++) read_one();
        check("t2_ptr", 32'(reg_ptr), 32'(ptr_m));
        check("t2_tlast", 32'(m_tlast), 32'd0);

        // Wrap at REG_COUNT-1 and modulo pointer load.
        send(8'd4, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b1);
        send(8'd7, 1'b1);
        idle_w();
        check("t3_ptr_mod", 32'(reg_ptr), 32'(ptr_m));

        // Write beat and read request in the same cycle while in WDATA.
        send(8'($urandom), 1'b0);
        b = 8'($urandom);
        model_byte(b, 1'b0);
        model_read();
        s_tdata = b; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        check("t4_tready_wdata", 32'(s_tready), 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("t4_wr_en", 32'(reg_wr_en), 32'd1);
        tr_hi = 0; n = 0;
        while (!m_tvalid && n < 50) begin
            if (s_tready) tr_hi++;
            n++;
            @(negedge clk);
        end
        check("t4_tvalid_seen", 32'(m_tvalid), 32'd1);
        check("t4_tready_low", 32'(tr_hi), 32'd0);
        check("t4_rd_after_wr", 32'(last_rd_cyc - last_wr_cyc), 32'd1);
        @(posedge clk); #1;
        m_tready = 1'b0;
        check("t4_ptr", 32'(reg_ptr), 32'(ptr_m));

        // Reset while holding a read byte.
        send(8'($urandom), 1'b1);
        idle_w();
        rda_q.push_back(8'(ptr_m));
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!m_tvalid && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        check("t5_hold_tvalid", 32'(m_tvalid), 32'd1);
        check("t5_hold_tready", 32'(s_tready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 0; first_m = 1'b1;
        check("t5_tvalid", 32'(m_tvalid), 32'd0);
        check("t5_tdata", 32'(m_tdata), 32'd0);
        check("t5_ptr", 32'(reg_ptr), 32'd0);
        check("t5_wr_en", 32'(reg_wr_en), 32'd0);
        send(8'd1, 1'b0); send(8'($urandom), 1'b1);
        idle_w();
        check("t5_after_ptr", 32'(reg_ptr), 32'(ptr_m));

        // Randomised mix of write sessions (some left open) and reads.
        repeat (60) begin
            if ($urandom_range(0, 1) == 1) begin
                nb   = int'($urandom_range(1, 5));
                endl = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < nb; i++) send(8'($urandom), (i == nb - 1) && endl);
                idle_w();
            end else begin
                nr = int'($urandom_range(1, 3));
                for (int i = 0; i < nr; i++) read_one();
            end
            check("rand_ptr", 32'(reg_ptr), 32'(ptr_m));
        end

`ifdef I2C_REG_CTRL_STATS_EN
        do_reset();
        send(8'h00, 1'b0);
        for (int i = 0; i < 70000; i++) send(8'($urandom), 1'b0);
        idle_w();
        @(posedge clk); #1;
        check("stat_wr_sat", 32'(wr_count), 32'h0000FFFF);
        for (int i = 0; i < 3; i++) read_one();
        check("stat_rd_count", 32'(rd_count), 32'd3);
        do_reset();
        check("stat_wr_clr", 32'(wr_count), 32'd0);
        check("stat_rd_clr", 32'(rd_count), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rda_q_empty", 32'(rda_q.size()), 32'd0);
        check("rdd_q_empty", 32'(rdd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
